// File: rtl/comm_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// comm_tx_fifo_if
// Bundles the write side (image_processing comm_data_out) and the read side
// (spi_interface spi_data_in) of the transmit byte FIFO.
//   flush     : synchronous clear of FIFO contents
//   wr_data   : byte to enqueue
//   wr_valid  : one-cycle write strobe
//   rd_req    : one-cycle request for the next byte
//   rd_data   : registered byte returned for each request
//   rd_valid  : one-cycle strobe, one cycle after rd_req
//   count     : occupancy 0..DEPTH
//   empty     : count == 0
//   full      : count == DEPTH
//   overflow  : sticky write-when-full flag (0 unless the option is built in)
// Modports: master = producer/consumer side, slave = FIFO.
// -----------------------------------------------------------------------------
interface comm_tx_fifo_if #(
    parameter int unsigned DEPTH = 16
) ();
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             flush;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             rd_req;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;

    modport master (
        output flush, wr_data, wr_valid, rd_req,
        input  rd_data, rd_valid, count, empty, full, overflow
    );

    modport slave (
        input  flush, wr_data, wr_valid, rd_req,
        output rd_data, rd_valid, count, empty, full, overflow
    );
endinterface

// File: rtl/comm_tx_fifo.sv
// -----------------------------------------------------------------------------
// comm_tx_fifo
// Byte FIFO between the image_processing response path and the SPI transmit
// path. Every rd_req is answered one cycle later with a one-cycle rd_valid;
// when the FIFO is empty the answer is a pad byte so the SPI link never stalls.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : comm_tx_fifo_if.slave (flush, wr_*, rd_*, count, empty, full,
//              overflow)
// Parameters:
//   DEPTH    : entries, power of two 4..256
//   PAD_BYTE : byte returned on a read while empty
// Build option:
//   COMM_TX_FIFO_OVERFLOW_EN : enables the sticky overflow flag and an 8-bit
//   saturating drop counter, which replaces PAD_BYTE on empty reads while
//   overflow is set. Undefined: overflow is tied 0.
// -----------------------------------------------------------------------------
module comm_tx_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
    input  logic            clk,
    input  logic            reset_n,
    comm_tx_fifo_if.slave   bus
);
    localparam int unsigned     PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             empty_w, full_w;
    logic             do_wr, do_rd;
    logic [7:0]       pad_w;

`ifdef COMM_TX_FIFO_OVERFLOW_EN
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             drop_w;
`endif

    always_comb begin
        empty_w = (count_q == '0);
        full_w  = (count_q == FULL_CNT);
        do_rd   = bus.rd_req && !empty_w && !bus.flush;
        // A read in the same cycle frees the slot, so a full FIFO still accepts.
        do_wr   = bus.wr_valid && (!full_w || bus.rd_req) && !bus.flush;
`ifdef COMM_TX_FIFO_OVERFLOW_EN
        drop_w  = bus.wr_valid && full_w && !bus.rd_req && !bus.flush;
        pad_w   = overflow_q ? drop_cnt_q : PAD_BYTE;
`else
        pad_w   = PAD_BYTE;
`endif
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef COMM_TX_FIFO_OVERFLOW_EN
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
`endif
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
`ifdef COMM_TX_FIFO_OVERFLOW_EN
            overflow_d = 1'b0;
            drop_cnt_d = '0;
`endif
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (bus.rd_req) begin
                rd_valid_d = 1'b1;
                rd_data_d  = do_rd ? mem_q[rd_ptr_q] : pad_w;
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
`ifdef COMM_TX_FIFO_OVERFLOW_EN
            if (drop_w) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef COMM_TX_FIFO_OVERFLOW_EN
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef COMM_TX_FIFO_OVERFLOW_EN
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
`ifdef COMM_TX_FIFO_OVERFLOW_EN
    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_comm_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_comm_tx_fifo
// Directed plus random stimulus against a queue-based reference of the FIFO.
// Expected read bytes go into a scoreboard queue; a monitor on the falling
// edge pops and compares whenever rd_valid is seen, and also checks the
// occupancy flags against the reference.
// -----------------------------------------------------------------------------
module tb_comm_tx_fifo;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    bit   done;

    byte unsigned m_q[$];
    byte unsigned exp_q[$];
    bit           m_ovf;
    byte unsigned m_drop;

    comm_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    comm_tx_fifo #(.DEPTH(DEPTH), .PAD_BYTE(8'hFF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_drop = 8'd0;
    endfunction

    function automatic byte unsigned pad_value();
`ifdef COMM_TX_FIFO_OVERFLOW_EN
        return m_ovf ? m_drop : 8'hFF;
`else
        return 8'hFF;
`endif
    endfunction

    function automatic bit exp_overflow();
`ifdef COMM_TX_FIFO_OVERFLOW_EN
        return m_ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: read first (frees a slot), then write if there is room.
    function automatic void model_step(input bit w, input byte unsigned d, input bit r, input bit f);
        if (f) begin
            model_reset();
            return;
        end
        if (r) begin
            if (m_q.size() > 0) exp_q.push_back(m_q.pop_front());
            else                exp_q.push_back(pad_value());
        end
        if (w) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else begin
                m_ovf = 1'b1;
                if (m_drop != 8'hFF) m_drop++;
            end
        end
    endfunction

    task automatic cycle(input bit w, input byte unsigned d, input bit r, input bit f);
        bus.wr_valid = w;
        bus.wr_data  = d;
        bus.rd_req   = r;
        bus.flush    = f;
        @(posedge clk);
        model_step(w, d, r, f);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor
    initial begin
        while (!done) begin
            @(negedge clk);
            if (done) break;
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
                else                   chk("rd_data", {24'd0, bus.rd_data}, {24'd0, exp_q.pop_front()});
            end else if (exp_q.size() != 0) begin
                chk("rd_valid_missing", 0, 1);
                exp_q.delete();
            end
            chk("count",    {27'd0, bus.count}, m_q.size());
            chk("empty",    {31'd0, bus.empty}, {31'd0, m_q.size() == 0});
            chk("full",     {31'd0, bus.full},  {31'd0, m_q.size() == DEPTH});
            chk("overflow", {31'd0, bus.overflow}, {31'd0, exp_overflow()});
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        done  = 1'b0;
        model_reset();
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_req   = 1'b0;
        bus.flush    = 1'b0;
        reset_n      = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rd_data",  {24'd0, bus.rd_data}, 32'h00);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 0);
        chk("rst_count",    {27'd0, bus.count}, 0);
        chk("rst_empty",    {31'd0, bus.empty}, 1);
        chk("rst_full",     {31'd0, bus.full}, 0);
        chk("rst_overflow", {31'd0, bus.overflow}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Three writes then three reads
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle();

        // Read while empty returns pad
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle();

        // Fill, drop one, drain, empty read (pad or drop count)
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        idle();

        // Full with simultaneous write and read
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle();

        // Interleaved traffic across the pointer wrap, occupancy 5..12
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            bit w;
            bit r;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (m_q.size() >= 12) w = 1'b0;
            if (m_q.size() <= 5)  r = 1'b0;
            cycle(w, 8'($urandom), r, 1'b0);
        end
        while (m_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle();

        // Random phases: write-heavy then read-heavy, occasional flush
        for (int i = 0; i < 300; i++) begin
            bit w;
            bit r;
            bit f;
            if (i < 150) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            f = ($urandom_range(0, 59) == 0);
            cycle(w, 8'($urandom), r, f);
        end
        idle();

        // Flush with a read and write in the same cycle
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        idle();
        chk("flush_count", {27'd0, bus.count}, 0);
        chk("flush_empty", {31'd0, bus.empty}, 1);

        // Asynchronous reset while a read response is pending
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        reset_n = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        chk("arst_rd_valid", {31'd0, bus.rd_valid}, 0);
        chk("arst_rd_data",  {24'd0, bus.rd_data}, 32'h00);
        chk("arst_count",    {27'd0, bus.count}, 0);
        chk("arst_empty",    {31'd0, bus.empty}, 1);
        chk("arst_full",     {31'd0, bus.full}, 0);
        chk("arst_overflow", {31'd0, bus.overflow}, 0);
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        idle();

        chk("scoreboard_drained", exp_q.size(), 0);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/comm_tx_fifo.md
Name: comm_tx_fifo

Overview:
- Byte FIFO between the image_processing response path (comm_data_out / comm_data_out_valid) and the spi_interface transmit path (spi_data_in / spi_data_in_valid).
- Absorbs bursts of result bytes produced faster than the SPI host clocks them out, and replies to each host byte request in a fixed latency.
- Pads with a fixed byte when empty, so the SPI link never stalls.

Parameters:
- DEPTH, 16, number of byte entries; power of two, 4..256.
- PTR_W, log2(DEPTH), pointer width; derived, not overridden.
- PAD_BYTE, 8'hFF, byte returned when a read is requested while empty.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of contents; pointers and count go to 0
- wr_data  in  8  byte from image_processing comm_data_out
- wr_valid  in  1  one-cycle write strobe (comm_data_out_valid)
- rd_req  in  1  one-cycle strobe from spi_interface requesting next byte
- rd_data  out  8  byte to spi_interface spi_data_in
- rd_valid  out  1  one-cycle strobe (spi_data_in_valid)
- count  out  PTR_W+1  current occupancy, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky write-when-full flag (see Optional Feature)

Behaviour:
- Reset (reset_n=0, asynchronous): wr_ptr=rd_ptr=0, count=0, rd_data=8'h00, rd_valid=0, empty=1, full=0, overflow=0. Storage array is not reset.
- Outputs are registered. empty, full and count are decoded from the registered count.
- Write: wr_valid=1 and not full -> mem[wr_ptr]<=wr_data, wr_ptr+1 (mod DEPTH), count+1. Visible in count and empty on the next cycle.
- Write when full, no simultaneous read: byte dropped. Pointers and count unchanged.
- Read: rd_req=1 and not empty -> rd_data<=mem[rd_ptr], rd_valid=1 on cycle N+1, rd_ptr+1 (mod DEPTH), count-1.
- Read when empty: rd_data<=PAD_BYTE, rd_valid=1 on N+1, state unchanged. The SPI side always receives a byte per request.
- rd_valid is high for exactly one cycle per rd_req. Back-to-back rd_req every cycle is supported.
- Simultaneous wr_valid and rd_req:
  - not empty and not full: both happen, count unchanged.
  - full: the read frees an entry, so the write is accepted. Count stays DEPTH and nothing is dropped.
  - empty: no bypass. The read returns PAD_BYTE and the write is stored (count 0->1).
- Pointer wrap: pointers are PTR_W bits and wrap naturally. Full and empty are distinguished by count only.
- flush (synchronous, highest priority after reset): pointers=0, count=0. A wr_valid or rd_req in the same cycle is ignored and rd_valid is 0 next cycle. overflow is also cleared.
- Reset mid-operation: everything returns to reset values immediately. A pending rd_valid is suppressed.
- No read or write combinational paths from input to output.

Optional Feature:
- Macro: COMM_TX_FIFO_OVERFLOW_EN.
- Defined:
  - overflow is set on the cycle after any dropped write, and stays 1 until flush or reset.
  - An 8-bit saturating drop counter is kept internally. It is readable by substituting it for PAD_BYTE on empty reads while overflow=1, so the host can detect lost bytes.
- Undefined: overflow is tied 0, the drop counter is absent, and empty reads always return PAD_BYTE.

Test Plan:
- Write 8'h11, 8'h22, 8'h33 on consecutive cycles; then 3 rd_req pulses -> rd_data 11, 22, 33, each with a one-cycle rd_valid one cycle after its rd_req; count ends 0, empty=1.
- rd_req on an empty FIFO after reset -> rd_data=8'hFF, rd_valid=1 one cycle later; count stays 0.
- Fill with DEPTH=16 bytes 0x00..0x0F -> full=1. A 17th write of 0xAA is dropped. Drain 16 bytes -> exactly 0x00..0x0F. With the macro: overflow=1, and the next empty read returns 8'h01.
- Full FIFO, wr_valid=1 (0x55) and rd_req=1 in the same cycle -> rd_data=0x00, count stays 16, full stays 1. The last byte drained is 0x55.
- 40 interleaved writes/reads crossing the pointer wrap at count 5..12 -> output sequence equals input order, with no PAD_BYTE.
- Load 5 bytes, then assert flush with rd_req in the same cycle -> no rd_valid, count=0, empty=1. Then deassert reset_n mid-burst -> all outputs return to reset values asynchronously.
